pool_frame_ctrl: RTL and testbench

- Sequences one DIM x DIM frame through the pooling datapath: reads pixels from the image buffer in raster order, feeds the datapath and holds it cleared between frames.
- Tags each pixel that completes a pooling window, delays the tag to match read and datapath latency, and writes the pooled result to the output buffer at a compact address.
- Sits between the frame-buffer memories and the pooling pipeline. Started by the layer scheduler through a start/busy/done handshake.

---
 rtl/pool_frame_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pool_frame_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_frame_ctrl.sv
`timescale 1ns/1ps
// Frame sequencer for pooling: raster reads, window tagging, compact output writes.
// Write lags pixel issue by RD_LAT+DP_LAT cycles; no backpressure, one fixed-length frame per start.
module pool_frame_ctrl #(
    parameter int DIM    = 28,
    parameter int K      = 2,
    parameter int STRIDE = 2,
    parameter int PP     = 8,
    parameter int AW     = 10,
    parameter int OAW    = 8,
    parameter int RD_LAT = 1,
    parameter int DP_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 img_rd_en,
    output logic [AW-1:0]        img_addr,
    input  logic [PP:0]          img_rd_data,
    output logic signed [PP:0]   dp_pxl,
    output logic                 dp_clear,
    input  logic signed [PP:0]   dp_result,
    output logic                 out_wr_en,
    output logic [OAW-1:0]       out_addr,
    output logic [PP:0]          out_data
);

    localparam int NOUT = (DIM - K) / STRIDE + 1;
    localparam int NWR  = NOUT * NOUT;
    localparam int TL   = RD_LAT + DP_LAT;
    localparam int CW   = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int PW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int DCW  = (TL > 1) ? $clog2(TL) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]  row;
    logic [CW-1:0]  col;
    logic [PW-1:0]  rph;
    logic [PW-1:0]  cph;
    logic [AW-1:0]  addr;
    logic [DCW-1:0] drain_cnt;
    logic [TL-1:0]  tag_sr;
    logic           col_end;
    logic           last_px;
    logic           tag_in;

    // Phase counters track (idx-(K-1)) mod STRIDE without a divider for any stride.
    function automatic logic [PW-1:0] ph_step(input logic [PW-1:0] p);
        return (p == PW'(STRIDE - 1)) ? '0 : p + PW'(1);
    endfunction

    assign col_end = (col == CW'(DIM - 1));
    assign last_px = col_end && (row == CW'(DIM - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        img_rd_en = 1'b0;
        dp_clear  = 1'b0;
        case (state)
            S_IDLE: begin
                busy     = 1'b0;
                dp_clear = 1'b1;
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                dp_clear  = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                img_rd_en = 1'b1;
                if (last_px) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DCW'(TL - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                dp_clear  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                dp_clear  = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row       <= '0;
            col       <= '0;
            rph       <= '0;
            cph       <= '0;
            addr      <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    row  <= '0;
                    col  <= '0;
                    rph  <= '0;
                    cph  <= '0;
                    addr <= '0;
                end
                S_STREAM: begin
                    if (last_px) begin
                        row  <= '0;
                        col  <= '0;
                        rph  <= '0;
                        cph  <= '0;
                        addr <= '0;
                    end else begin
                        addr <= addr + AW'(1);
                        if (col_end) begin
                            col <= '0;
                            cph <= '0;
                            row <= row + CW'(1);
                            rph <= (row + CW'(1) == CW'(K - 1)) ? '0 : ph_step(rph);
                        end else begin
                            col <= col + CW'(1);
                            cph <= (col + CW'(1) == CW'(K - 1)) ? '0 : ph_step(cph);
                        end
                    end
                end
                default: begin
                end
            endcase
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + DCW'(1) : '0;
        end
    end

    // A pixel completes a window when it is the bottom-right corner of one.
    assign tag_in = img_rd_en && (row >= CW'(K - 1)) && (col >= CW'(K - 1)) &&
                    (rph == '0) && (cph == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_sr <= '0;
        end else begin
            tag_sr[0] <= tag_in;
            for (int i = 1; i < TL; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    // Saturates at the last window so the address never wraps past the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_addr <= '0;
        end else if (state == S_CLEAR) begin
            out_addr <= '0;
        end else if (out_wr_en && (out_addr != OAW'(NWR - 1))) begin
            out_addr <= out_addr + OAW'(1);
        end
    end

    assign img_addr  = addr;
    assign dp_pxl    = img_rd_data;
    assign out_wr_en = tag_sr[TL-1];
    assign out_data  = dp_result;

endmodule

// File: tb/tb_pool_frame_ctrl.sv
`timescale 1ns/1ps
// Bench for pool_frame_ctrl: three instances (4x4 stride 2, 4x4 stride 1, 28x28 default)
// with an image memory model and an echo datapath, checked against a window-rule model.
module tb_pool_frame_ctrl;

    localparam int NI  = 3;
    localparam int LAT = 2;

    typedef struct {
        int kind;
        int inst;
        int addr;
        int data;
        int cyc;
    } ev_t;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [NI-1:0] start, busy, done, rd_en, wr_en, dclr;
    logic [3:0]    ia0, ia1;
    logic [9:0]    ia2;
    logic [1:0]    oa0;
    logic [3:0]    oa1;
    logic [7:0]    oa2;
    logic [8:0]    rd0, rd1, rd2, od0, od1, od2;
    logic signed [8:0] px0, px1, px2, res0, res1, res2;
    logic [8:0]    img [NI][1024];

    int  cyc = 0;
    int  nvec = 0;
    int  nerr = 0;
    ev_t evq[$];
    wr_t exp_q[$];
    wr_t act_q[$];
    int  ss_q[$];
    int  dn_q[$];
    logic [NI-1:0] prev_rd = '0;

    pool_frame_ctrl #(.DIM(4), .K(2), .STRIDE(2), .PP(8), .AW(4), .OAW(2), .RD_LAT(1), .DP_LAT(1)) u_s2 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .img_rd_en(rd_en[0]), .img_addr(ia0), .img_rd_data(rd0), .dp_pxl(px0), .dp_clear(dclr[0]),
        .dp_result(res0), .out_wr_en(wr_en[0]), .out_addr(oa0), .out_data(od0));

    pool_frame_ctrl #(.DIM(4), .K(2), .STRIDE(1), .PP(8), .AW(4), .OAW(4), .RD_LAT(1), .DP_LAT(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .img_rd_en(rd_en[1]), .img_addr(ia1), .img_rd_data(rd1), .dp_pxl(px1), .dp_clear(dclr[1]),
        .dp_result(res1), .out_wr_en(wr_en[1]), .out_addr(oa1), .out_data(od1));

    pool_frame_ctrl u_def (
        .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .img_rd_en(rd_en[2]), .img_addr(ia2), .img_rd_data(rd2), .dp_pxl(px2), .dp_clear(dclr[2]),
        .dp_result(res2), .out_wr_en(wr_en[2]), .out_addr(oa2), .out_data(od2));

    // One-cycle image memory and a datapath that echoes its pixel one cycle later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en[0]) rd0 <= img[0][ia0];
        if (rd_en[1]) rd1 <= img[1][ia1];
        if (rd_en[2]) rd2 <= img[2][ia2];
        res0 <= px0;
        res1 <= px1;
        res2 <= px2;
    end

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < NI; i++) begin
                int a, d;
                a = (i == 0) ? int'(oa0) : (i == 1) ? int'(oa1) : int'(oa2);
                d = (i == 0) ? int'(od0) : (i == 1) ? int'(od1) : int'(od2);
                if (rd_en[i] && !prev_rd[i]) evq.push_back('{1, i, 0, 0, cyc});
                if (wr_en[i]) evq.push_back('{0, i, a, d, cyc});
                if (done[i]) evq.push_back('{2, i, 0, 0, cyc});
            end
        end
        prev_rd = rd_en;
    end

    // Expected writes from the window rule: address is the window's raster index,
    // data is the corner pixel, cycle is relative to the first streamed pixel.
    function automatic void build_exp(int i, int dim, int k, int s);
        int n;
        n = 0;
        exp_q.delete();
        for (int r = 0; r < dim; r++) begin
            for (int c = 0; c < dim; c++) begin
                if (r >= k - 1 && c >= k - 1 && (r - (k - 1)) % s == 0 && (c - (k - 1)) % s == 0) begin
                    exp_q.push_back('{n, int'(img[i][r * dim + c]), r * dim + c + LAT});
                    n++;
                end
            end
        end
    endfunction

    function automatic void gather(int i);
        act_q.delete();
        ss_q.delete();
        dn_q.delete();
        for (int k = 0; k < evq.size(); k++) begin
            if (evq[k].inst == i) begin
                if (evq[k].kind == 0) act_q.push_back('{evq[k].addr, evq[k].data, evq[k].cyc});
                else if (evq[k].kind == 1) ss_q.push_back(evq[k].cyc);
                else dn_q.push_back(evq[k].cyc);
            end
        end
    endfunction

    task automatic fill(input int i, input bool_rand);
        for (int a = 0; a < 1024; a++) begin
            img[i][a] = bool_rand ? 9'($urandom_range(0, 511)) : 9'(a);
        end
    endtask

    task automatic wait_done(input int i, input int budget, output int ok);
        ok = 0;
        for (int t = 0; t < budget && ok == 0; t++) begin
            @(negedge clk);
            if (done[i]) ok = 1;
        end
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            int ra, wa;
            ra = (i == 0) ? int'(ia0) : (i == 1) ? int'(ia1) : int'(ia2);
            wa = (i == 0) ? int'(oa0) : (i == 1) ? int'(oa1) : int'(oa2);
            nvec++;
            if ({busy[i], done[i], rd_en[i], wr_en[i], dclr[i]} !== 5'b00001) begin
                nerr++;
                $display("FAIL reset_ctl inst%0d got %b want 00001", i, {busy[i], done[i], rd_en[i], wr_en[i], dclr[i]});
            end
            nvec++;
            if (ra != 0 || wa != 0) begin
                nerr++;
                $display("FAIL reset_addr inst%0d got img %0d out %0d want 0 0", i, ra, wa);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stride2;
        int ok, ss;
        fill(0, 0);
        evq.delete();
        pulse_start(0);
        nvec++;
        if ({busy[0], dclr[0], rd_en[0]} !== 3'b110) begin
            nerr++;
            $display("FAIL clear_state got %b want 110", {busy[0], dclr[0], rd_en[0]});
        end
        @(negedge clk);
        nvec++;
        if ({rd_en[0], dclr[0], ia0} !== {1'b1, 1'b0, 4'd0}) begin
            nerr++;
            $display("FAIL stream_first got %b want 1_0_0000", {rd_en[0], dclr[0], ia0});
        end
        wait_done(0, 100, ok);
        nvec++;
        if (ok == 0) begin
            nerr++;
            $display("FAIL s2_done_timeout got 0 want 1");
        end
        @(negedge clk);
        nvec++;
        if ({busy[0], dclr[0], done[0]} !== 3'b010) begin
            nerr++;
            $display("FAIL idle_after_done got %b want 010", {busy[0], dclr[0], done[0]});
        end
        repeat (3) @(negedge clk);
        gather(0);
        build_exp(0, 4, 2, 2);
        ss = (ss_q.size() > 0) ? ss_q[0] : 0;
        nvec++;
        if (act_q.size() != 4 || exp_q.size() != 4) begin
            nerr++;
            $display("FAIL s2_count got %0d want 4", act_q.size());
        end
        nvec++;
        if (dn_q.size() != 1 || ss_q.size() != 1 || dn_q[0] - ss != 16 + LAT) begin
            nerr++;
            $display("FAIL s2_done got %0d dones want 1 at rel %0d", dn_q.size(), 16 + LAT);
        end
        for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
            nvec++;
            if (act_q[k].addr != exp_q[k].addr || act_q[k].data != exp_q[k].data || act_q[k].cyc - ss != exp_q[k].cyc) begin
                nerr++;
                $display("FAIL s2_wr%0d got a%0d d%0d t%0d want a%0d d%0d t%0d", k, act_q[k].addr, act_q[k].data,
                         act_q[k].cyc - ss, exp_q[k].addr, exp_q[k].data, exp_q[k].cyc);
            end
        end
    endtask

    task automatic test_stride1;
        int ok, ss;
        fill(1, 0);
        evq.delete();
        pulse_start(1);
        wait_done(1, 100, ok);
        nvec++;
        if (ok == 0) begin
            nerr++;
            $display("FAIL s1_done_timeout got 0 want 1");
        end
        repeat (3) @(negedge clk);
        gather(1);
        build_exp(1, 4, 2, 1);
        ss = (ss_q.size() > 0) ? ss_q[0] : 0;
        nvec++;
        if (act_q.size() != 9) begin
            nerr++;
            $display("FAIL s1_count got %0d want 9", act_q.size());
        end
        for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
            nvec++;
            if (act_q[k].addr != exp_q[k].addr || act_q[k].data != exp_q[k].data || act_q[k].cyc - ss != exp_q[k].cyc) begin
                nerr++;
                $display("FAIL s1_wr%0d got a%0d d%0d t%0d want a%0d d%0d t%0d", k, act_q[k].addr, act_q[k].data,
                         act_q[k].cyc - ss, exp_q[k].addr, exp_q[k].data, exp_q[k].cyc);
            end
        end
    endtask

    task automatic test_start_held;
        int ok, f;
        fill(0, 1);
        evq.delete();
        pulse_start(0);
        repeat (6) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (11) @(negedge clk);
        start[0] = 1'b1;
        wait_done(0, 100, ok);
        @(negedge clk);
        nvec++;
        if (busy[0] !== 1'b0) begin
            nerr++;
            $display("FAIL held_idle_busy got %b want 0", busy[0]);
        end
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 100, ok);
        nvec++;
        if (ok == 0) begin
            nerr++;
            $display("FAIL held_done_timeout got 0 want 1");
        end
        repeat (6) @(negedge clk);
        gather(0);
        build_exp(0, 4, 2, 2);
        nvec++;
        if (ss_q.size() != 2 || dn_q.size() != 2) begin
            nerr++;
            $display("FAIL held_frames got %0d starts %0d dones want 2 2", ss_q.size(), dn_q.size());
        end else begin
            nvec++;
            if (dn_q[0] - ss_q[0] != 16 + LAT || ss_q[1] - dn_q[0] != 3) begin
                nerr++;
                $display("FAIL held_timing got len %0d gap %0d want %0d 3", dn_q[0] - ss_q[0], ss_q[1] - dn_q[0], 16 + LAT);
            end
            nvec++;
            if (act_q.size() != 8) begin
                nerr++;
                $display("FAIL held_count got %0d want 8", act_q.size());
            end
            for (int k = 0; k < act_q.size() && k < 8; k++) begin
                f = k / 4;
                nvec++;
                if (act_q[k].addr != exp_q[k % 4].addr || act_q[k].data != exp_q[k % 4].data ||
                    act_q[k].cyc - ss_q[f] != exp_q[k % 4].cyc) begin
                    nerr++;
                    $display("FAIL held_wr%0d got a%0d d%0d t%0d want a%0d d%0d t%0d", k, act_q[k].addr, act_q[k].data,
                             act_q[k].cyc - ss_q[f], exp_q[k % 4].addr, exp_q[k % 4].data, exp_q[k % 4].cyc);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int ok, ss;
        fill(0, 1);
        evq.delete();
        pulse_start(0);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        nvec++;
        if ({busy[0], rd_en[0], wr_en[0], dclr[0], oa0, ia0} !== {4'b0001, 2'd0, 4'd0}) begin
            nerr++;
            $display("FAIL mid_reset_state got %b want 0001_00_0000", {busy[0], rd_en[0], wr_en[0], dclr[0], oa0, ia0});
        end
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            nvec++;
            if (wr_en[0] !== 1'b0) begin
                nerr++;
                $display("FAIL mid_reset_wr cyc%0d got %b want 0", t, wr_en[0]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        evq.delete();
        pulse_start(0);
        wait_done(0, 100, ok);
        nvec++;
        if (ok == 0) begin
            nerr++;
            $display("FAIL mid_done_timeout got 0 want 1");
        end
        repeat (3) @(negedge clk);
        gather(0);
        build_exp(0, 4, 2, 2);
        ss = (ss_q.size() > 0) ? ss_q[0] : 0;
        nvec++;
        if (act_q.size() != 4) begin
            nerr++;
            $display("FAIL mid_count got %0d want 4", act_q.size());
        end
        for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
            nvec++;
            if (act_q[k].addr != exp_q[k].addr || act_q[k].data != exp_q[k].data || act_q[k].cyc - ss != exp_q[k].cyc) begin
                nerr++;
                $display("FAIL mid_wr%0d got a%0d d%0d t%0d want a%0d d%0d t%0d", k, act_q[k].addr, act_q[k].data,
                         act_q[k].cyc - ss, exp_q[k].addr, exp_q[k].data, exp_q[k].cyc);
            end
        end
    endtask

    task automatic test_defaults;
        int ok, ss;
        fill(2, 1);
        evq.delete();
        pulse_start(2);
        wait_done(2, 1000, ok);
        nvec++;
        if (ok == 0) begin
            nerr++;
            $display("FAIL def_done_timeout got 0 want 1");
        end
        repeat (3) @(negedge clk);
        gather(2);
        build_exp(2, 28, 2, 2);
        ss = (ss_q.size() > 0) ? ss_q[0] : 0;
        nvec++;
        if (act_q.size() != 196 || dn_q.size() != 1) begin
            nerr++;
            $display("FAIL def_count got %0d writes %0d dones want 196 1", act_q.size(), dn_q.size());
        end
        if (act_q.size() > 0) begin
            nvec++;
            if (act_q[0].cyc - ss != 31 || act_q[$].addr != 195) begin
                nerr++;
                $display("FAIL def_edges got first t%0d last a%0d want t31 a195", act_q[0].cyc - ss, act_q[$].addr);
            end
        end
        for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
            nvec++;
            if (act_q[k].addr != exp_q[k].addr || act_q[k].data != exp_q[k].data || act_q[k].cyc - ss != exp_q[k].cyc) begin
                nerr++;
                $display("FAIL def_wr%0d got a%0d d%0d t%0d want a%0d d%0d t%0d", k, act_q[k].addr, act_q[k].data,
                         act_q[k].cyc - ss, exp_q[k].addr, exp_q[k].data, exp_q[k].cyc);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = '0;
        for (int i = 0; i < NI; i++) fill(i, 0);
        test_reset();
        test_stride2();
        test_stride1();
        test_start_held();
        test_reset_mid();
        test_defaults();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 20000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
